// File: rtl/mdu_ctrl_if.sv
// EXE <-> HI/LO multiply/divide unit request bus and architectural HI/LO view.
interface mdu_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // EXE side: issues operations and flushes
  modport master (
    output req_valid, req_op, src_a, src_b, flush,
    input  req_ready, busy, done, hi, lo
  );

  // MDU side: sequences the operation and owns HI/LO
  modport slave (
    input  req_valid, req_op, src_a, src_b, flush,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 1-bit/cycle
// restoring divide, MTHI/MTLO writes, and flush abort of in-flight work.
module mdu_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_LAT    = 2
) (
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        accept, commit_mul, commit_div;

  logic [31:0] a_q;        // raw src_a (multiplicand, or dividend for the /0 result)
  logic [31:0] b_q;        // multiplier, or divisor magnitude
  logic        sgn_q;      // signed multiply
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic        negq_q, negr_q, dz_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt, quo_fix, rem_fix;
  logic [63:0] a_ext, b_ext, prod;
  logic        div_signed;

  // Two's-complement negate when n is set (magnitudes and sign correction).
  function automatic logic [31:0] cond_neg(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, b_q};
  assign rem_nxt = ge ? 32'(shifted - {1'b0, b_q}) : shifted[31:0];
  assign quo_nxt = {quo_q[30:0], ge};

  // Divide by zero returns all-ones / dividend untouched by sign correction.
  assign quo_fix = dz_q ? 32'hFFFF_FFFF : cond_neg(negq_q, quo_nxt);
  assign rem_fix = dz_q ? a_q : cond_neg(negr_q, rem_nxt);

  // Low 64 bits of a 64x64 product of extended operands give both MULT and MULTU.
  assign a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = a_ext * b_ext;

  assign div_signed = (bus.req_op == OP_DIV);

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;

  // Next-state, accept and commit decode; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    commit_mul    = 1'b0;
    commit_div    = 1'b0;
    bus.busy      = (state_q != IDLE);
    bus.req_ready = (state_q == IDLE) && !bus.flush && !reset;
    accept        = bus.req_valid && bus.req_ready &&
                    (bus.req_op != 3'd0) && (bus.req_op != 3'd7);
    case (state_q)
      IDLE: begin
        if (accept && (bus.req_op == OP_MULT || bus.req_op == OP_MULTU)) begin
          state_d = MUL;
          cnt_d   = 6'(MUL_LAT - 1);
        end else if (accept && (bus.req_op == OP_DIV || bus.req_op == OP_DIVU)) begin
          state_d = DIV;
          cnt_d   = 6'(DIV_CYCLES - 1);
        end
      end
      MUL: begin
        if (cnt_q == 6'd0) begin
          commit_mul = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV: begin
        if (cnt_q == 6'd0) begin
          commit_div = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d    = IDLE;
      commit_mul = 1'b0;
      commit_div = 1'b0;
    end
  end

  // State and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit_mul || commit_div;
      if (accept && bus.req_op == OP_MTHI) hi_q <= bus.src_a;
      if (accept && bus.req_op == OP_MTLO) lo_q <= bus.src_a;
      if (commit_mul) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end
      if (commit_div) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end
    end
  end

  // Operand capture at accept, then one divide iteration per DIV cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= bus.src_a;
      sgn_q  <= (bus.req_op == OP_MULT);
      dz_q   <= (bus.src_b == 32'd0);
      negq_q <= div_signed && (bus.src_a[31] ^ bus.src_b[31]);
      negr_q <= div_signed && bus.src_a[31];
      rem_q  <= 32'd0;
      quo_q  <= cond_neg(div_signed && bus.src_a[31], bus.src_a);
      b_q    <= (bus.req_op == OP_DIV || bus.req_op == OP_DIVU) ?
                cond_neg(div_signed && bus.src_b[31], bus.src_b) : bus.src_b;
    end else if (state_q == DIV) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized operations
// against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;
  localparam int MUL_LAT    = 2;
  localparam int DIV_CYCLES = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [31:0] m_hi, m_lo;

  mdu_ctrl_if bus();

  mdu_ctrl #(.DIV_CYCLES(DIV_CYCLES), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation; returns accept-to-done latency (0 = none).
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint sp, sa, sb, q, r;
    longint unsigned up;
    lat = 0;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0]; lat = MUL_LAT + 1;
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; lat = MUL_LAT + 1;
      end
      3'd3: begin
        lat = DIV_CYCLES + 1;
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: begin
        lat = DIV_CYCLES + 1;
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: lat = 0;
    endcase
  endtask

  // Issue one operation at a negedge and follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int lat, cyc;
    logic got;
    model(op, a, b, lat);
    bus.req_valid = 1'b1; bus.req_op = op; bus.src_a = a; bus.src_b = b;
    chk({tag, "_ready"}, bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    if (lat == 0) begin
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_hi"}, bus.hi, m_hi);
      chk({tag, "_lo"}, bus.lo, m_lo);
      return;
    end
    chk({tag, "_busy"}, bus.busy, 1);
    cyc = 1; got = 1'b0;
    while (!got && cyc <= 40) begin
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
    chk({tag, "_rdy_at_done"}, bus.req_ready, 1);
    @(negedge clk);
    chk({tag, "_done_off"}, bus.done, 0);
  endtask

  initial begin
    int lat, cyc, early;
    logic seen;
    logic [2:0]  op;
    logic [31:0] a, b;
    n_cmp = 0; n_bad = 0; m_hi = 0; m_lo = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.src_a = 0; bus.src_b = 0; bus.flush = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1);

    // Back-to-back MTHI / MTLO
    run_op("mthi", 3'd5, 32'h1234_5678, 32'd0);
    run_op("mtlo", 3'd6, 32'h9ABC_DEF0, 32'd0);
    chk("mthi_lit", bus.hi, 32'h1234_5678);

    // Multiplies
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_lit", bus.lo, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi_lit", bus.hi, 32'h0000_0002);

    // Divides and corner cases
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_lit", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_lit", bus.hi, 32'hFFFF_FFFF);
    run_op("divu", 3'd4, 32'd100, 32'd7);
    chk("divu_lo_lit", bus.lo, 32'd14);
    run_op("divu_z", 3'd4, 32'h55, 32'd0);
    chk("divu_z_lo_lit", bus.lo, 32'hFFFF_FFFF);
    run_op("div_z_neg", 3'd3, 32'h8000_0007, 32'd0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_lit", bus.lo, 32'h8000_0000);

    // Flush mid-divide
    run_op("mthi_a5", 3'd5, 32'hA5A5_A5A5, 32'd0);
    run_op("mtlo_a5", 3'd6, 32'hA5A5_A5A5, 32'd0);
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd3;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    chk("fl10_busy", bus.busy, 1);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl10_busy_off", bus.busy, 0);
    seen = 1'b0;
    repeat (40) begin
      if (bus.done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("fl10_no_done", seen, 0);
    chk("fl10_hi", bus.hi, m_hi);
    chk("fl10_lo", bus.lo, m_lo);

    // Flush on the commit cycle
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.src_a = 32'd1000; bus.src_b = 32'd9;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    repeat (DIV_CYCLES - 1) @(negedge clk);
    chk("flc_busy_last", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flc_done", bus.done, 0);
    chk("flc_busy", bus.busy, 0);
    bus.flush = 1'b0;
    chk("flc_hi", bus.hi, 32'hA5A5_A5A5);
    chk("flc_lo", bus.lo, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("flc_done2", bus.done, 0);

    // Request held during a divide is taken only in the done cycle
    model(3'd4, 32'd100, 32'd7, lat);
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    bus.req_op = 3'd6; bus.src_a = 32'h0BAD_F00D;
    cyc = 1; early = 0;
    while (bus.done !== 1'b1 && cyc <= 40) begin
      if (bus.req_ready !== 1'b0) early++;
      @(negedge clk);
      cyc++;
    end
    chk("hold_lat", cyc, lat);
    chk("hold_no_early", early, 0);
    chk("hold_lo_quot", bus.lo, m_lo);
    chk("hold_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    m_lo = 32'h0BAD_F00D;
    chk("hold_lo_mt", bus.lo, m_lo);
    chk("hold_hi", bus.hi, m_hi);

    // Flush in IDLE blocks acceptance
    bus.flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.src_a = 32'h777;
    @(negedge clk);
    chk("fli_ready", bus.req_ready, 0);
    chk("fli_hi_kept", bus.hi, m_hi);
    bus.flush = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    m_hi = 32'h777;
    chk("fli_hi_new", bus.hi, m_hi);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    // Reset mid-operation
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.src_a = 32'd12345; bus.src_b = 32'd7;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_op = 3'd0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_hi", bus.hi, 0);
    chk("rmid_lo", bus.lo, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    chk("rmid_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource used by EXE-stage hi_lo_op instructions.
- Accepts one request at a time from EXE, runs a fixed-latency multiply or an iterative restoring divide, and owns the HI/LO architectural registers.
- Drives busy/ready so EXE can stall, and aborts in-flight work on pipeline flush (exception/eret).

Parameters:
- DIV_CYCLES, 32, divide iteration count; one quotient bit per cycle; must be 32 for a 32-bit result.
- MUL_LAT, 2, cycles spent in MUL state before commit; legal range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE presents an operation
- req_op  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0 and 7 are ignored (no accept)
- src_a  in  32  rs value; dividend/multiplicand; MTHI/MTLO data
- src_b  in  32  rt value; divisor/multiplier
- flush  in  1  pipeline_flush.ex or pipeline_flush.eret
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just updated by a mul/div
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset values:
  - state=IDLE; hi=0, lo=0, done=0, busy=0.
  - req_ready=0 while reset is high; it follows the normal rule from the first cycle after reset.
- States: IDLE, MUL, DIV.
  - busy = (state != IDLE).
  - req_ready = (state == IDLE) && !flush.
- Accept: at the edge where req_valid && req_ready && req_op in 1..6, operands are latched.
- MTHI/MTLO:
  - Never leave IDLE.
  - hi (or lo) = src_a at the accept edge.
  - No done pulse, so back-to-back accepts are possible every cycle.
- MULT/MULTU:
  - IDLE->MUL. The counter loads MUL_LAT-1, decrements each cycle, and the state exits when it reaches 0.
  - At the exit edge: {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU); state->IDLE; done=1 for the next cycle.
  - Accept-to-done latency is MUL_LAT+1 cycles.
- DIV/DIVU:
  - IDLE->DIV. Operands are converted to magnitudes (DIV only), and the signs of quotient (a^b) and remainder (a) are saved.
  - One restoring iteration per cycle for DIV_CYCLES cycles, using a 33-bit partial remainder and a 6-bit counter.
  - At the final edge: lo = sign-corrected quotient, hi = sign-corrected remainder; state->IDLE; done pulses.
  - Latency is DIV_CYCLES+1 cycles, i.e. 33.
- Divide by zero:
  - Runs the full length with no exception.
  - Result: lo=0xFFFFFFFF, hi=src_a, with no sign correction for either DIV or DIVU.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): lo=0x80000000, hi=0.
- Flush:
  - A high flush in any cycle forces state->IDLE at the next edge.
  - The in-flight result is discarded: hi/lo are unchanged and no done pulse is produced.
  - Flush in the same cycle as the commit edge: flush wins and nothing is written.
  - Flush in IDLE blocks acceptance that cycle via req_ready=0.
- done is low in every cycle not immediately following a commit edge.
- Reset mid-operation behaves as reset: IDLE, hi/lo cleared.
- req_valid while busy is ignored; EXE must hold the request. req_ready rises in the cycle done is high, so a new request can be accepted then.

Test Plan:
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0 one edge after each accept; busy stays 0.
- MULT 0xFFFFFFFE x 0x00000003 -> done 3 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> done 33 cycles after accept; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 0x55 / 0 -> lo=0xFFFFFFFF, hi=0x55 after 33 cycles. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started with hi=lo=0xA5A5A5A5, flush asserted at cycle 10 -> busy=0 next cycle, no done, hi/lo still 0xA5A5A5A5. Repeat with flush on the commit cycle -> same result.
- Request held valid during a 33-cycle DIV -> accepted only in the done cycle; a new request with flush high in IDLE -> not accepted until flush drops.
